// File: rtl/dot_product_n.sv
// dot_product_n: N-lane signed dot product with a registered adder tree and
// optional multi-beat accumulation. Define DOT_SATURATE_EN to clamp out on overflow.
module dot_product_n #(
  parameter int N           = 4,
  parameter int WIDTH       = 32,
  parameter int FIXED_POINT = 0,
  parameter int ACC_GUARD   = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_in,
  input  logic [N*WIDTH-1:0] x_in,
  input  logic [N*WIDTH-1:0] y_in,
  input  logic               acc_in,
  input  logic               last_in,
  output logic [WIDTH-1:0]   out,
  output logic               valid_out,
  output logic               overflow_out
);

  localparam int D  = $clog2(N);
  localparam int TW = WIDTH + D;
  localparam int AW = TW + ACC_GUARD;
  localparam int PW = 2 * WIDTH;

`ifdef DOT_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef struct packed {
    logic valid;
    logic acc;
    logic last;
  } ctl_t;

  logic signed [PW-1:0]    prod [N];
  logic signed [WIDTH-1:0] lane [N];
  logic signed [TW-1:0]    node [D+1][N];
  ctl_t                    ctl  [D+1];

  // Fixed point keeps the middle WIDTH bits of the product (arithmetic floor).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = PW'($signed(x_in[i*WIDTH +: WIDTH])) * PW'($signed(y_in[i*WIDTH +: WIDTH]));
      lane[i] = (FIXED_POINT != 0) ? WIDTH'(prod[i] >>> (WIDTH/2)) : WIDTH'(prod[i]);
    end
  end

  // NOTE: datapath registers carry no reset; the control flags alone decide what is valid.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < N; i++) begin
      node[0][i] <= TW'(lane[i]);
    end
  end

  // Each tree level halves the live node count; an odd leftover is passed through.
  for (genvar l = 0; l < D; l++) begin : g_lvl
    localparam int CI = (N + (1 << l) - 1) >> l;
    for (genvar j = 0; j < N; j++) begin : g_node
      if (2*j + 1 < CI) begin : g_add
        always_ff @(posedge clk_in) node[l+1][j] <= node[l][2*j] + node[l][2*j+1];
      end else if (2*j < CI) begin : g_pass
        always_ff @(posedge clk_in) node[l+1][j] <= node[l][2*j];
      end else begin : g_zero
        always_ff @(posedge clk_in) node[l+1][j] <= '0;
      end
    end
  end

  // NOTE: non-blocking assignments so each stage takes its predecessor's pre-edge value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int l = 0; l <= D; l++) begin
        ctl[l] <= '0;
      end
    end else begin
      ctl[0] <= '{valid: valid_in, acc: acc_in, last: last_in};
      for (int l = 0; l < D; l++) begin
        ctl[l+1] <= ctl[l];
      end
    end
  end

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] sum_ext;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] result;
  logic                 emit;
  logic                 ovf;
  logic [WIDTH-1:0]     narrow;

  // NOTE: every output of this block is assigned before any conditional, so no latch forms.
  always_comb begin
    sum_ext  = AW'(node[D][0]);
    acc_next = acc_q + sum_ext;
    result   = ctl[D].acc ? acc_next : sum_ext;
    emit     = ctl[D].valid && (!ctl[D].acc || ctl[D].last);
    ovf      = (result[AW-1:WIDTH-1] != '0) && (result[AW-1:WIDTH-1] != '1);
    narrow   = result[WIDTH-1:0];
`ifdef DOT_SATURATE_EN
    if (ovf) begin
      narrow = result[AW-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  // The accumulator clears on the closing beat so the next group starts from zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q        <= '0;
      out          <= '0;
      valid_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      valid_out    <= emit;
      overflow_out <= emit && ovf;
      if (emit) begin
        out <= narrow;
      end
      if (ctl[D].valid && ctl[D].acc) begin
        acc_q <= ctl[D].last ? '0 : acc_next;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_n.sv
// tb_dot_product_n: randomized bench for dot_product_n (integer and fixed-point
// instances) against an arithmetic reference model; honours DOT_SATURATE_EN.
module tb_dot_product_n;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int G     = 8;
  localparam int L     = 2 + $clog2(N);
  localparam int AWB   = W + $clog2(N) + G;
  localparam int DEPTH = 256;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  logic           clk      = 1'b0;
  logic           rst_in   = 1'b1;
  logic           valid_in = 1'b0;
  logic           acc_in   = 1'b0;
  logic           last_in  = 1'b0;
  logic [N*W-1:0] x_in     = '0;
  logic [N*W-1:0] y_in     = '0;
  logic [W-1:0]   out_i, out_f;
  logic           valid_i, valid_f, ovf_i, ovf_f;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected outputs indexed by the cycle in which they must be observed.
  bit           exp_v  [DEPTH];
  logic [W-1:0] exp_oi [DEPTH];
  logic [W-1:0] exp_of [DEPTH];
  bit           exp_fi [DEPTH];
  bit           exp_ff [DEPTH];
  longint       accm_i, accm_f;
  logic [W-1:0] hold_i, hold_f;

  dot_product_n #(.N(N), .WIDTH(W), .FIXED_POINT(0), .ACC_GUARD(G)) dut (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
    .acc_in(acc_in), .last_in(last_in), .out(out_i), .valid_out(valid_i), .overflow_out(ovf_i)
  );

  dot_product_n #(.N(N), .WIDTH(W), .FIXED_POINT(1), .ACC_GUARD(G)) dut_fx (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
    .acc_in(acc_in), .last_in(last_in), .out(out_f), .valid_out(valid_f), .overflow_out(ovf_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic longint lane_term(input logic [W-1:0] a, input logic [W-1:0] b, input bit fx);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (fx) p = p >>> (W/2);
    return longint'($signed(p[W-1:0]));
  endfunction

  function automatic longint dot(input logic [N*W-1:0] xv, input logic [N*W-1:0] yv, input bit fx);
    longint s = 0;
    for (int i = 0; i < N; i++) s += lane_term(xv[i*W +: W], yv[i*W +: W], fx);
    return s;
  endfunction

  function automatic longint wrap_aw(input longint v);
    return (v <<< (64 - AWB)) >>> (64 - AWB);
  endfunction

  function automatic logic [W-1:0] narrow_val(input longint r);
    logic [W-1:0] o;
    o = r[W-1:0];
`ifdef DOT_SATURATE_EN
    if (r > MAXV) o = MAXV[W-1:0];
    if (r < MINV) o = MINV[W-1:0];
`endif
    return o;
  endfunction

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N*W-1:0] rnd_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < DEPTH; s++) begin
      exp_v[s] = 1'b0; exp_oi[s] = '0; exp_of[s] = '0; exp_fi[s] = 1'b0; exp_ff[s] = 1'b0;
    end
    accm_i = 0; accm_f = 0; hold_i = '0; hold_f = '0;
  endtask

  // Drives one beat at a negedge and records what both instances must show L cycles on.
  task automatic drive(input bit v, input bit a, input bit l, input logic [N*W-1:0] xv, input logic [N*W-1:0] yv);
    longint si, sf, ri, rf;
    bit     emit;
    int     s;
    valid_in = v; acc_in = a; last_in = l; x_in = xv; y_in = yv;
    emit = v && (!a || l);
    s    = (cyc + L) % DEPTH;
    ri = 0; rf = 0;
    if (v) begin
      si = dot(xv, yv, 1'b0);
      sf = dot(xv, yv, 1'b1);
      if (a) begin
        accm_i = wrap_aw(accm_i + si);
        accm_f = wrap_aw(accm_f + sf);
        ri = accm_i; rf = accm_f;
        if (l) begin accm_i = 0; accm_f = 0; end
      end else begin
        ri = si; rf = sf;
      end
    end
    if (emit) begin
      hold_i = narrow_val(ri);
      hold_f = narrow_val(rf);
    end
    exp_v[s]  = emit;
    exp_oi[s] = hold_i;
    exp_of[s] = hold_f;
    exp_fi[s] = emit && (ri > MAXV || ri < MINV);
    exp_ff[s] = emit && (rf > MAXV || rf < MINV);
  endtask

  task automatic test_reset();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      valid_in = 1'b1; acc_in = 1'b0; x_in = rnd_vec(); y_in = rnd_vec();
      n_tests += 6;
      if (valid_i !== 1'b0) begin n_fail++; $display("FAIL reset valid_out(int) got %b want 0", valid_i); end
      if (out_i !== '0) begin n_fail++; $display("FAIL reset out(int) got %h want 0", out_i); end
      if (ovf_i !== 1'b0) begin n_fail++; $display("FAIL reset overflow_out(int) got %b want 0", ovf_i); end
      if (valid_f !== 1'b0) begin n_fail++; $display("FAIL reset valid_out(fx) got %b want 0", valid_f); end
      if (out_f !== '0) begin n_fail++; $display("FAIL reset out(fx) got %h want 0", out_f); end
      if (ovf_f !== 1'b0) begin n_fail++; $display("FAIL reset overflow_out(fx) got %b want 0", ovf_f); end
    end
    rst_in = 1'b0;
    clear_model();
    drive(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
  endtask

  task automatic test_integer();
    int s;
    for (int t = 0; t < L + 3; t++) begin
      @(negedge clk);
      s = cyc % DEPTH;
      n_tests += 6;
      if (valid_i !== exp_v[s]) begin n_fail++; $display("FAIL integer valid_out(int) cyc=%0d got %b want %b", cyc, valid_i, exp_v[s]); end
      if (out_i !== exp_oi[s]) begin n_fail++; $display("FAIL integer out(int) cyc=%0d got %h want %h", cyc, out_i, exp_oi[s]); end
      if (ovf_i !== exp_fi[s]) begin n_fail++; $display("FAIL integer overflow_out(int) cyc=%0d got %b want %b", cyc, ovf_i, exp_fi[s]); end
      if (valid_f !== exp_v[s]) begin n_fail++; $display("FAIL integer valid_out(fx) cyc=%0d got %b want %b", cyc, valid_f, exp_v[s]); end
      if (out_f !== exp_of[s]) begin n_fail++; $display("FAIL integer out(fx) cyc=%0d got %h want %h", cyc, out_f, exp_of[s]); end
      if (ovf_f !== exp_ff[s]) begin n_fail++; $display("FAIL integer overflow_out(fx) cyc=%0d got %b want %b", cyc, ovf_f, exp_ff[s]); end
      if (t == L) begin
        n_tests++;
        if (valid_i !== 1'b1 || out_i !== 32'd70 || ovf_i !== 1'b0) begin
          n_fail++; $display("FAIL integer 70 at latency got v=%b out=%0d ovf=%b want v=1 out=70 ovf=0", valid_i, out_i, ovf_i);
        end
      end
      if (t == 0) drive(1'b1, 1'b0, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
      else        drive(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
    end
  endtask

  task automatic test_fixed_point();
    int s;
    for (int t = 0; t < L + 4; t++) begin
      @(negedge clk);
      s = cyc % DEPTH;
      n_tests += 6;
      if (valid_i !== exp_v[s]) begin n_fail++; $display("FAIL fixed valid_out(int) cyc=%0d got %b want %b", cyc, valid_i, exp_v[s]); end
      if (out_i !== exp_oi[s]) begin n_fail++; $display("FAIL fixed out(int) cyc=%0d got %h want %h", cyc, out_i, exp_oi[s]); end
      if (ovf_i !== exp_fi[s]) begin n_fail++; $display("FAIL fixed overflow_out(int) cyc=%0d got %b want %b", cyc, ovf_i, exp_fi[s]); end
      if (valid_f !== exp_v[s]) begin n_fail++; $display("FAIL fixed valid_out(fx) cyc=%0d got %b want %b", cyc, valid_f, exp_v[s]); end
      if (out_f !== exp_of[s]) begin n_fail++; $display("FAIL fixed out(fx) cyc=%0d got %h want %h", cyc, out_f, exp_of[s]); end
      if (ovf_f !== exp_ff[s]) begin n_fail++; $display("FAIL fixed overflow_out(fx) cyc=%0d got %b want %b", cyc, ovf_f, exp_ff[s]); end
      if (t == L) begin
        n_tests++;
        if (out_f !== 32'h0003_0000) begin n_fail++; $display("FAIL fixed 1.5*2.0 got %h want 00030000", out_f); end
      end
      if (t == L + 1) begin
        n_tests++;
        if (out_f !== 32'hFFFF_C000) begin n_fail++; $display("FAIL fixed -0.5*0.5 got %h want ffffc000", out_f); end
      end
      if (t == 0)      drive(1'b1, 1'b0, 1'b0, pack4(32'h0001_8000, 0, 0, 0), pack4(32'h0002_0000, 0, 0, 0));
      else if (t == 1) drive(1'b1, 1'b0, 1'b0, pack4(32'hFFFF_8000, 0, 0, 0), pack4(32'h0000_8000, 0, 0, 0));
      else             drive(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
    end
  endtask

  task automatic test_accumulate();
    int s;
    logic [N*W-1:0] ones;
    ones = pack4(1, 1, 1, 1);
    for (int t = 0; t < L + 8; t++) begin
      @(negedge clk);
      s = cyc % DEPTH;
      n_tests += 6;
      if (valid_i !== exp_v[s]) begin n_fail++; $display("FAIL accumulate valid_out(int) cyc=%0d got %b want %b", cyc, valid_i, exp_v[s]); end
      if (out_i !== exp_oi[s]) begin n_fail++; $display("FAIL accumulate out(int) cyc=%0d got %h want %h", cyc, out_i, exp_oi[s]); end
      if (ovf_i !== exp_fi[s]) begin n_fail++; $display("FAIL accumulate overflow_out(int) cyc=%0d got %b want %b", cyc, ovf_i, exp_fi[s]); end
      if (valid_f !== exp_v[s]) begin n_fail++; $display("FAIL accumulate valid_out(fx) cyc=%0d got %b want %b", cyc, valid_f, exp_v[s]); end
      if (out_f !== exp_of[s]) begin n_fail++; $display("FAIL accumulate out(fx) cyc=%0d got %h want %h", cyc, out_f, exp_of[s]); end
      if (ovf_f !== exp_ff[s]) begin n_fail++; $display("FAIL accumulate overflow_out(fx) cyc=%0d got %b want %b", cyc, ovf_f, exp_ff[s]); end
      if (t == L + 2 || t == L + 5) begin
        n_tests++;
        if (valid_i !== 1'b1 || out_i !== 32'd12) begin
          n_fail++; $display("FAIL accumulate group result got v=%b out=%0d want v=1 out=12", valid_i, out_i);
        end
      end
      if (t < 6) drive(1'b1, 1'b1, (t == 2 || t == 5), ones, ones);
      else       drive(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
    end
  endtask

  task automatic test_overflow();
    int s;
    logic [W-1:0] want;
`ifdef DOT_SATURATE_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'hFFFF_FFFC;
`endif
    for (int t = 0; t < L + 3; t++) begin
      @(negedge clk);
      s = cyc % DEPTH;
      n_tests += 6;
      if (valid_i !== exp_v[s]) begin n_fail++; $display("FAIL overflow valid_out(int) cyc=%0d got %b want %b", cyc, valid_i, exp_v[s]); end
      if (out_i !== exp_oi[s]) begin n_fail++; $display("FAIL overflow out(int) cyc=%0d got %h want %h", cyc, out_i, exp_oi[s]); end
      if (ovf_i !== exp_fi[s]) begin n_fail++; $display("FAIL overflow overflow_out(int) cyc=%0d got %b want %b", cyc, ovf_i, exp_fi[s]); end
      if (valid_f !== exp_v[s]) begin n_fail++; $display("FAIL overflow valid_out(fx) cyc=%0d got %b want %b", cyc, valid_f, exp_v[s]); end
      if (out_f !== exp_of[s]) begin n_fail++; $display("FAIL overflow out(fx) cyc=%0d got %h want %h", cyc, out_f, exp_of[s]); end
      if (ovf_f !== exp_ff[s]) begin n_fail++; $display("FAIL overflow overflow_out(fx) cyc=%0d got %b want %b", cyc, ovf_f, exp_ff[s]); end
      if (t == L) begin
        n_tests++;
        if (ovf_i !== 1'b1 || out_i !== want) begin
          n_fail++; $display("FAIL overflow max lanes got ovf=%b out=%h want ovf=1 out=%h", ovf_i, out_i, want);
        end
      end
      if (t == 0) drive(1'b1, 1'b0, 1'b0, {N{32'h7FFF_FFFF}}, pack4(1, 1, 1, 1));
      else        drive(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
    end
  endtask

  task automatic test_streaming();
    int s;
    bit a, l;
    for (int t = 0; t < 20 + L + 2; t++) begin
      @(negedge clk);
      s = cyc % DEPTH;
      n_tests += 6;
      if (valid_i !== exp_v[s]) begin n_fail++; $display("FAIL streaming valid_out(int) cyc=%0d got %b want %b", cyc, valid_i, exp_v[s]); end
      if (out_i !== exp_oi[s]) begin n_fail++; $display("FAIL streaming out(int) cyc=%0d got %h want %h", cyc, out_i, exp_oi[s]); end
      if (ovf_i !== exp_fi[s]) begin n_fail++; $display("FAIL streaming overflow_out(int) cyc=%0d got %b want %b", cyc, ovf_i, exp_fi[s]); end
      if (valid_f !== exp_v[s]) begin n_fail++; $display("FAIL streaming valid_out(fx) cyc=%0d got %b want %b", cyc, valid_f, exp_v[s]); end
      if (out_f !== exp_of[s]) begin n_fail++; $display("FAIL streaming out(fx) cyc=%0d got %h want %h", cyc, out_f, exp_of[s]); end
      if (ovf_f !== exp_ff[s]) begin n_fail++; $display("FAIL streaming overflow_out(fx) cyc=%0d got %b want %b", cyc, ovf_f, exp_ff[s]); end
      if (t < 20) begin
        a = ($urandom_range(0, 2) != 0);
        l = a && ($urandom_range(0, 2) == 0);
        if (t == 19 && a) l = 1'b1;
        drive(1'b1, a, l, rnd_vec(), rnd_vec());
      end else begin
        drive(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
      end
    end
  endtask

  task automatic test_reset_mid_group();
    int s;
    logic [N*W-1:0] ones;
    ones = pack4(1, 1, 1, 1);
    for (int t = 0; t < L + 5; t++) begin
      @(negedge clk);
      s = cyc % DEPTH;
      n_tests += 6;
      if (valid_i !== exp_v[s]) begin n_fail++; $display("FAIL reset_mid valid_out(int) cyc=%0d got %b want %b", cyc, valid_i, exp_v[s]); end
      if (out_i !== exp_oi[s]) begin n_fail++; $display("FAIL reset_mid out(int) cyc=%0d got %h want %h", cyc, out_i, exp_oi[s]); end
      if (ovf_i !== exp_fi[s]) begin n_fail++; $display("FAIL reset_mid overflow_out(int) cyc=%0d got %b want %b", cyc, ovf_i, exp_fi[s]); end
      if (valid_f !== exp_v[s]) begin n_fail++; $display("FAIL reset_mid valid_out(fx) cyc=%0d got %b want %b", cyc, valid_f, exp_v[s]); end
      if (out_f !== exp_of[s]) begin n_fail++; $display("FAIL reset_mid out(fx) cyc=%0d got %h want %h", cyc, out_f, exp_of[s]); end
      if (ovf_f !== exp_ff[s]) begin n_fail++; $display("FAIL reset_mid overflow_out(fx) cyc=%0d got %b want %b", cyc, ovf_f, exp_ff[s]); end
      if (t == L + 2) begin
        n_tests++;
        if (valid_i !== 1'b1 || out_i !== 32'd4) begin
          n_fail++; $display("FAIL reset_mid post-reset group got v=%b out=%0d want v=1 out=4", valid_i, out_i);
        end
      end
      if (t < 2) begin
        drive(1'b1, 1'b1, 1'b0, rnd_vec(), rnd_vec());
      end else if (t == 2) begin
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
        clear_model();
        drive(1'b1, 1'b1, 1'b1, ones, ones);
      end else begin
        drive(1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_fixed_point();
    test_accumulate();
    test_overflow();
    test_streaming();
    test_reset_mid_group();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
